acc_id_scheduler: RTL and testbench

ACC_ID_SCHEDULER -- requirements
Module: acc_id_scheduler

---
 rtl/acc_pkg.sv | 18 +
 rtl/lzc.sv | 31 +++
 rtl/acc_id_scheduler.sv | 118 +++++++++++
 tb/tb_acc_id_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : acc_pkg
// Purpose : Shared ID width and scheduler FSM state type.
// Revision: 1.0
// ============================================================================
package acc_pkg;

  localparam int unsigned IdWidth = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/lzc.sv
`default_nettype none
// ============================================================================
// Module  : lzc
// Purpose : Leading/trailing zero counter (MODE=0 trailing, MODE=1 leading).
// Revision: 1.0
// ============================================================================
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // Scan from the far end so the last hit (nearest the counting origin) wins.
  always_comb begin
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (MODE == 1'b0) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(i);
      end else begin
        if (in_i[WIDTH-1-i]) cnt_o = CNT_WIDTH'(i);
      end
    end
    empty_o = ~|in_i;
  end

endmodule
`default_nettype wire

// File: rtl/acc_id_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : acc_id_scheduler
// Purpose : Allocates transaction IDs to offload requests and retires them
//           on observed responses, limiting the number in flight.
// Revision: 1.0
// ============================================================================
module acc_id_scheduler
  import acc_pkg::*;
#(
  parameter int unsigned NumIds         = 32,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  in_q_valid_i,
  output logic                                  in_q_ready_o,
  output logic                                  out_q_valid_o,
  input  logic                                  out_q_ready_i,
  output logic [IdWidth-1:0]                    id_o,
  input  logic                                  rsp_valid_i,
  input  logic                                  rsp_ready_i,
  input  logic [IdWidth-1:0]                    rsp_id_i,
  input  logic                                  flush_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  busy_o,
  output logic                                  err_o
);

  localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
  localparam int unsigned     LzcW   = (NumIds > 1) ? $clog2(NumIds) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  state_e              state, state_next;
  logic [NumIds-1:0]   bitmap, bitmap_next;
  logic [CntW-1:0]     count;
  logic                lock;
  logic [IdWidth-1:0]  locked_id;

  logic [LzcW-1:0]     free_idx;
  logic                none_free;
  logic                can_issue, issue, retire, rsp_known, rsp_good;
  logic [31:0]         bitmap_ext, set_mask, clr_mask;

  lzc #(
    .WIDTH    (NumIds),
    .MODE     (1'b0),
    .CNT_WIDTH(LzcW)
  ) u_lzc (
    .in_i   (~bitmap),
    .cnt_o  (free_idx),
    .empty_o(none_free)
  );

  assign id_o       = lock ? locked_id : IdWidth'(free_idx);
  assign bitmap_ext = 32'(bitmap);
  assign rsp_known  = (32'(rsp_id_i) < NumIds) && bitmap_ext[rsp_id_i];

  assign can_issue = (state != DRAIN) && !flush_i && (count < MaxCnt) && !none_free;
  assign issue     = in_q_valid_i && out_q_ready_i && can_issue;
  assign retire    = rsp_valid_i && rsp_ready_i;
  assign rsp_good  = retire && rsp_known;

  // Outputs are forced low during reset regardless of the input handshake.
  assign out_q_valid_o = in_q_valid_i && can_issue && !rst_i;
  assign in_q_ready_o  = out_q_ready_i && can_issue && !rst_i;
  assign err_o         = retire && !rsp_known && !rst_i;
  assign busy_o        = (state != IDLE);
  assign outstanding_o = count;

  assign set_mask    = issue    ? (32'd1 << id_o)     : 32'd0;
  assign clr_mask    = rsp_good ? (32'd1 << rsp_id_i) : 32'd0;
  assign bitmap_next = (bitmap | set_mask[NumIds-1:0]) & ~clr_mask[NumIds-1:0];

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (flush_i)    state_next = DRAIN;
        else if (issue) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (flush_i)                         state_next = DRAIN;
        else if (count == '0 && !issue)      state_next = IDLE;
      end
      DRAIN: begin
        if (count == '0 && !flush_i)         state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      bitmap    <= '0;
      count     <= '0;
      lock      <= 1'b0;
      locked_id <= '0;
    end else begin
      state  <= state_next;
      bitmap <= bitmap_next;
      if (issue && !rsp_good && count != MaxCnt)
        count <= count + CntW'(1);
      else if (!issue && rsp_good && count != '0)
        count <= count - CntW'(1);
      // A stalled request keeps its ID so the interconnect sees a stable payload.
      if (issue) begin
        lock <= 1'b0;
      end else if (in_q_valid_i && can_issue && !out_q_ready_i) begin
        lock      <= 1'b1;
        locked_id <= id_o;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_id_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_acc_id_scheduler
// Purpose : Self-checking bench: vector table, corner sequences, random run.
// Revision: 1.0
// ============================================================================
module tb_acc_id_scheduler;

  typedef struct {
    bit in_v;
    bit o_rdy;
    bit rsp_v;
    bit rsp_r;
    int rsp_id;
    bit flush;
  } stim_t;

  typedef struct {
    stim_t s;
    int    ovalid;
    int    iready;
    int    id;
    int    cnt;
    int    busy;
    int    err;
  } vec_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       in_q_valid_i, out_q_ready_i, rsp_valid_i, rsp_ready_i, flush_i;
  logic [4:0] rsp_id_i;
  logic       in_q_ready_o, out_q_valid_o, busy_o, err_o;
  logic [4:0] id_o;
  logic [3:0] outstanding_o;

  int checks = 0;
  int errors = 0;

  // Reference model: set of outstanding IDs, count, mode and stall latch.
  bit [31:0] m_ids;
  int        m_cnt;
  int        m_mode;  // 0 idle, 1 active, 2 draining
  bit        m_lock;
  int        m_lid;
  int        e_ovalid, e_iready, e_id, e_err;

  always #5 clk_i = ~clk_i;

  acc_id_scheduler #(.NumIds(32), .MaxOutstanding(8)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_q_valid_i (in_q_valid_i),
    .in_q_ready_o (in_q_ready_o),
    .out_q_valid_o(out_q_valid_o),
    .out_q_ready_i(out_q_ready_i),
    .id_o         (id_o),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_i     (rsp_id_i),
    .flush_i      (flush_i),
    .outstanding_o(outstanding_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic stim_t mk(bit iv, bit ordy, bit rv, bit rr, int rid, bit fl);
    stim_t s;
    s.in_v = iv; s.o_rdy = ordy; s.rsp_v = rv; s.rsp_r = rr; s.rsp_id = rid; s.flush = fl;
    return s;
  endfunction

  function automatic vec_t mv(stim_t s, int ov, int ir, int id, int cnt, int busy, int err);
    vec_t v;
    v.s = s; v.ovalid = ov; v.iready = ir; v.id = id; v.cnt = cnt; v.busy = busy; v.err = err;
    return v;
  endfunction

  task automatic model_reset();
    m_ids = '0; m_cnt = 0; m_mode = 0; m_lock = 1'b0; m_lid = 0;
  endtask

  task automatic model_eval();
    int  low;
    bit  can;
    low = 0;
    for (int i = 31; i >= 0; i--) if (!m_ids[i]) low = i;
    can      = (m_mode != 2) && !flush_i && (m_cnt < 8) && (m_ids != 32'hFFFF_FFFF);
    e_id     = m_lock ? m_lid : low;
    e_ovalid = (in_q_valid_i && can) ? 1 : 0;
    e_iready = (out_q_ready_i && can) ? 1 : 0;
    e_err    = (rsp_valid_i && rsp_ready_i && !m_ids[rsp_id_i]) ? 1 : 0;
  endtask

  task automatic model_step();
    bit issue, good;
    int old_cnt;
    issue   = (e_ovalid == 1) && out_q_ready_i;
    good    = rsp_valid_i && rsp_ready_i && m_ids[rsp_id_i];
    old_cnt = m_cnt;
    if (issue) m_ids[e_id] = 1'b1;
    if (good)  m_ids[rsp_id_i] = 1'b0;
    m_cnt = m_cnt + (issue ? 1 : 0) - (good ? 1 : 0);
    if (issue) m_lock = 1'b0;
    else if (e_ovalid == 1) begin m_lock = 1'b1; m_lid = e_id; end
    if (m_mode != 2 && flush_i)                    m_mode = 2;
    else if (m_mode == 0 && issue)                 m_mode = 1;
    else if (m_mode == 1 && old_cnt == 0 && !issue) m_mode = 0;
    else if (m_mode == 2 && old_cnt == 0 && !flush_i) m_mode = 0;
  endtask

  task automatic drive(input stim_t s);
    in_q_valid_i  = s.in_v;
    out_q_ready_i = s.o_rdy;
    rsp_valid_i   = s.rsp_v;
    rsp_ready_i   = s.rsp_r;
    rsp_id_i      = 5'(s.rsp_id);
    flush_i       = s.flush;
    #1;
  endtask

  task automatic tick();
    model_eval();
    chk("m_ovalid", out_q_valid_o, e_ovalid);
    chk("m_iready", in_q_ready_o, e_iready);
    chk("m_id", id_o, e_id);
    chk("m_cnt", outstanding_o, m_cnt);
    chk("m_busy", busy_o, (m_mode != 0) ? 1 : 0);
    chk("m_err", err_o, e_err);
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0));
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  vec_t  tbl[16];
  stim_t s;

  initial begin
    rst_i = 1'b1;
    drive(mk(1, 1, 1, 1, 4, 0));
    chk("rst_ovalid", out_q_valid_o, 0);
    chk("rst_iready", in_q_ready_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cnt", outstanding_o, 0);
    do_reset();

    for (int i = 0; i < 8; i++) tbl[i] = mv(mk(1, 1, 0, 0, 0, 0), 1, 1, i, i, (i > 0) ? 1 : 0, 0);
    tbl[8]  = mv(mk(1, 1, 0, 0, 0, 0),  0, 0, 8, 8, 1, 0);
    tbl[9]  = mv(mk(0, 1, 1, 1, 3, 0),  0, 0, 8, 8, 1, 0);
    tbl[10] = mv(mk(1, 1, 0, 0, 0, 0),  1, 1, 3, 7, 1, 0);
    tbl[11] = mv(mk(0, 1, 1, 1, 0, 0),  0, 0, 8, 8, 1, 0);
    tbl[12] = mv(mk(1, 1, 1, 1, 1, 0),  1, 1, 0, 7, 1, 0);
    tbl[13] = mv(mk(0, 0, 0, 0, 0, 0),  0, 0, 1, 7, 1, 0);
    tbl[14] = mv(mk(0, 0, 1, 1, 12, 0), 0, 0, 1, 7, 1, 1);
    tbl[15] = mv(mk(0, 0, 0, 0, 0, 0),  0, 0, 1, 7, 1, 0);

    for (int v = 0; v < 16; v++) begin
      drive(tbl[v].s);
      chk($sformatf("v%0d_ovalid", v), out_q_valid_o, tbl[v].ovalid);
      chk($sformatf("v%0d_iready", v), in_q_ready_o, tbl[v].iready);
      chk($sformatf("v%0d_id", v), id_o, tbl[v].id);
      chk($sformatf("v%0d_cnt", v), outstanding_o, tbl[v].cnt);
      chk($sformatf("v%0d_busy", v), busy_o, tbl[v].busy);
      chk($sformatf("v%0d_err", v), err_o, tbl[v].err);
      tick();
    end

    // Stalled request keeps its ID even when a lower one is freed.
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(mk(1, 1, 0, 0, 0, 0)); tick(); end
    drive(mk(1, 0, 1, 1, 0, 0));
    chk("lock_id0", id_o, 3);
    chk("lock_ovalid", out_q_valid_o, 1);
    chk("lock_iready", in_q_ready_o, 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(mk(1, 0, 0, 0, 0, 0));
      chk($sformatf("lock_hold%0d", k), id_o, 3);
      tick();
    end
    drive(mk(1, 1, 0, 0, 0, 0));
    chk("lock_issue_id", id_o, 3);
    chk("lock_issue_rdy", in_q_ready_o, 1);
    tick();
    drive(mk(0, 0, 0, 0, 0, 0));
    chk("lock_after_id", id_o, 0);
    chk("lock_after_cnt", outstanding_o, 3);
    tick();

    // Flush with two outstanding, drain, then return to idle.
    do_reset();
    for (int i = 0; i < 2; i++) begin drive(mk(1, 1, 0, 0, 0, 0)); tick(); end
    drive(mk(1, 1, 0, 0, 0, 1));
    chk("fl_ovalid", out_q_valid_o, 0);
    chk("fl_iready", in_q_ready_o, 0);
    tick();
    drive(mk(1, 1, 1, 1, 0, 1));
    chk("fl_busy0", busy_o, 1);
    chk("fl_ovalid1", out_q_valid_o, 0);
    tick();
    drive(mk(1, 1, 1, 1, 1, 1));
    chk("fl_ovalid2", out_q_valid_o, 0);
    tick();
    drive(mk(1, 1, 0, 0, 0, 0));
    chk("fl_drain_busy", busy_o, 1);
    chk("fl_drain_ovalid", out_q_valid_o, 0);
    chk("fl_drain_cnt", outstanding_o, 0);
    tick();
    drive(mk(0, 0, 0, 0, 0, 0));
    chk("fl_idle_busy", busy_o, 0);
    tick();

    // Reset in the middle of a burst abandons the in-flight IDs.
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(mk(1, 1, 0, 0, 0, 0)); tick(); end
    drive(mk(1, 1, 1, 1, 2, 0));
    #2;
    rst_i = 1'b1;
    #1;
    chk("mr_ovalid", out_q_valid_o, 0);
    chk("mr_iready", in_q_ready_o, 0);
    chk("mr_busy", busy_o, 0);
    chk("mr_err", err_o, 0);
    chk("mr_cnt", outstanding_o, 0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    drive(mk(1, 1, 0, 0, 0, 0));
    chk("mr_first_id", id_o, 0);
    tick();
    drive(mk(0, 0, 1, 1, 3, 0));
    chk("mr_late_err", err_o, 1);
    tick();
    drive(mk(0, 0, 0, 0, 0, 0));
    chk("mr_err_clear", err_o, 0);
    chk("mr_cnt_after", outstanding_o, 1);
    tick();

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      int rid;
      rid = int'($urandom_range(31, 0));
      if (($urandom % 5) != 0 && m_ids != 0) begin
        int start;
        start = rid;
        for (int j = 0; j < 32; j++) begin
          if (m_ids[(start + j) % 32]) begin rid = (start + j) % 32; break; end
        end
      end
      s = mk(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 2) != 0,
             ($urandom % 4) != 0, rid, ($urandom % 25) == 0);
      drive(s);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
